// File: rtl/studio2_kp_pkg.sv
// Shared constants and scan-code decode for the Studio II keypad block.
package studio2_kp_pkg;

    localparam int unsigned NUM_KEYS = 10;
    localparam logic [2:0] KEYPAD_OUT_PORT = 3'd2;

    localparam logic [7:0] KP1_CODES [NUM_KEYS] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    localparam logic [7:0] KP2_CODES [NUM_KEYS] = '{
        8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
    };

    typedef struct packed {
        logic       hit1;
        logic       hit2;
        logic [3:0] idx;
    } kp_hit_t;

    function automatic kp_hit_t kp_decode(input logic [7:0] code, input logic ext);
        kp_hit_t r;
        r = '0;
        if (!ext) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (code == KP1_CODES[i]) begin
                    r.hit1 = 1'b1;
                    r.idx  = 4'(i);
                end
                if (code == KP2_CODES[i]) begin
                    r.hit2 = 1'b1;
                    r.idx  = 4'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/studio2_keypad_bank.sv
// One 10-key keypad: effective pressed vector, deferred releases and the shared hold counter.
module studio2_keypad_bank
    import studio2_kp_pkg::*;
#(
    parameter int unsigned      CNT_W       = 24,
    parameter logic [CNT_W-1:0] HOLD_CYCLES = 24'd1_000_000
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                press,
    input  logic                rel,
    input  logic [3:0]          idx,
    output logic [NUM_KEYS-1:0] state
);

    logic [NUM_KEYS-1:0] state_q, state_d;
    logic [NUM_KEYS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] key_oh;
    logic                expire;

    always_comb begin
        key_oh = '0;
        if (idx < 4'(NUM_KEYS)) key_oh[idx] = 1'b1;
    end

    always_comb begin
        // A press in the expiry cycle reloads the counter and keeps pending releases alive.
        expire  = (cnt_q == CNT_W'(1)) && !press;
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

        if (expire) begin
            state_d = state_q & ~pend_q;
            pend_d  = '0;
        end

        if (press) begin
            state_d = state_d | key_oh;
            pend_d  = pend_d & ~key_oh;
            cnt_d   = HOLD_CYCLES;
        end else if (rel && ((state_d & key_oh) != '0)) begin
            // Release during a running hold is deferred; otherwise it lands immediately.
            if (cnt_q > CNT_W'(1)) pend_d  = pend_d | key_oh;
            else                   state_d = state_d & ~key_oh;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/studio2_keypad.sv
// PS/2 to RCA Studio II keypad bridge: event detect, decode, OUT 2 key latch and EF3/EF4 flags.
module studio2_keypad
    import studio2_kp_pkg::*;
#(
    parameter logic [23:0] HOLD_CYCLES = 24'd1_000_000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        io_out,
    input  logic [2:0]  io_n,
    input  logic [7:0]  cpu_dout,
    output logic [3:0]  key_latch,
    output logic        ef3_n,
    output logic        ef4_n,
    output logic [9:0]  kp1_state,
    output logic [9:0]  kp2_state
);

    logic       tgl_q, init_q;
    logic       ev;
    kp_hit_t    hit;
    logic       press1, rel1, press2, rel2;
    logic [3:0] latch_q, latch_d;
    logic       ef3_q, ef3_d, ef4_q, ef4_d;
    logic [15:0] kp1_pad, kp2_pad;
    logic       unused_dout;

    // init_q suppresses a false event before the toggle history has been sampled.
    assign ev  = init_q && (ps2_key[10] != tgl_q);
    assign hit = kp_decode(ps2_key[7:0], ps2_key[8]);

    assign press1 = ev && hit.hit1 && ps2_key[9];
    assign rel1   = ev && hit.hit1 && !ps2_key[9];
    assign press2 = ev && hit.hit2 && ps2_key[9];
    assign rel2   = ev && hit.hit2 && !ps2_key[9];

    studio2_keypad_bank #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (CNT_W'(HOLD_CYCLES))
    ) u_bank1 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .press   (press1),
        .rel     (rel1),
        .idx     (hit.idx),
        .state   (kp1_state)
    );

    studio2_keypad_bank #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (CNT_W'(HOLD_CYCLES))
    ) u_bank2 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .press   (press2),
        .rel     (rel2),
        .idx     (hit.idx),
        .state   (kp2_state)
    );

    // Zero padding makes latch values 10..15 read as "not pressed".
    assign kp1_pad = {6'b0, kp1_state};
    assign kp2_pad = {6'b0, kp2_state};

    always_comb begin
        latch_d = latch_q;
        if (io_out && (io_n == KEYPAD_OUT_PORT)) latch_d = cpu_dout[3:0];
        ef3_d = ~kp1_pad[latch_q];
        ef4_d = ~kp2_pad[latch_q];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tgl_q   <= 1'b0;
            init_q  <= 1'b0;
            latch_q <= '0;
            ef3_q   <= 1'b1;
            ef4_q   <= 1'b1;
        end else begin
            tgl_q   <= ps2_key[10];
            init_q  <= 1'b1;
            latch_q <= latch_d;
            ef3_q   <= ef3_d;
            ef4_q   <= ef4_d;
        end
    end

    assign unused_dout = ^cpu_dout[7:4];

    assign key_latch = latch_q;
    assign ef3_n     = ef3_q;
    assign ef4_n     = ef4_q;

endmodule

// File: tb/tb_studio2_keypad.sv
// Directed and randomized checks of studio2_keypad against a deadline-based keypad model.
module tb_studio2_keypad;

    localparam int HOLD = 100;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic        io_out = 1'b0;
    logic [2:0]  io_n = '0;
    logic [7:0]  cpu_dout = '0;
    logic [3:0]  key_latch;
    logic        ef3_n, ef4_n;
    logic [9:0]  kp1_state, kp2_state;

    int checks = 0;
    int errors = 0;

    studio2_keypad #(
        .HOLD_CYCLES (24'd100),
        .CNT_W       (24)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .io_out    (io_out),
        .io_n      (io_n),
        .cpu_dout  (cpu_dout),
        .key_latch (key_latch),
        .ef3_n     (ef3_n),
        .ef4_n     (ef4_n),
        .kp1_state (kp1_state),
        .kp2_state (kp2_state)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] kp1_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] kp2_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                   8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    // Model: per keypad a pressed set, a set of releases waiting on a deadline cycle.
    int         cyc = 0;
    logic       m_init, m_tgl;
    logic [9:0] m_eff [2];
    logic [9:0] m_pend [2];
    int         m_deadline [2];
    bit         m_have [2];
    logic [3:0] m_latch;
    logic       m_ef3, m_ef4;

    function automatic void model_reset();
        m_init = 1'b0;
        m_tgl  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_eff[k] = '0;
            m_pend[k] = '0;
            m_deadline[k] = 0;
            m_have[k] = 1'b0;
        end
        m_latch = '0;
        m_ef3 = 1'b1;
        m_ef4 = 1'b1;
    endfunction

    function automatic void model_decode(input logic [7:0] code, input logic ext,
                                         output int pad, output int key);
        pad = -1;
        key = 0;
        if (!ext) begin
            for (int i = 0; i < 10; i++) begin
                if (code == kp1_codes[i]) begin pad = 0; key = i; end
                if (code == kp2_codes[i]) begin pad = 1; key = i; end
            end
        end
    endfunction

    // Advance one clock with the currently driven inputs, updating the model alongside.
    task automatic tick();
        int c;
        int pad, key;
        logic ev, pr;
        logic [9:0] oh;
        logic new_ef3, new_ef4;
        c = cyc;
        new_ef3 = (m_latch <= 4'd9) ? !m_eff[0][m_latch] : 1'b1;
        new_ef4 = (m_latch <= 4'd9) ? !m_eff[1][m_latch] : 1'b1;
        ev = m_init && (ps2_key[10] != m_tgl);
        pad = -1;
        key = 0;
        if (ev) model_decode(ps2_key[7:0], ps2_key[8], pad, key);
        for (int k = 0; k < 2; k++) begin
            pr = (pad == k) && ps2_key[9];
            if (m_have[k] && c == m_deadline[k] && !pr) begin
                m_eff[k] = m_eff[k] & ~m_pend[k];
                m_pend[k] = '0;
                m_have[k] = 1'b0;
            end
        end
        if (pad >= 0) begin
            oh = 10'b1 << key;
            if (ps2_key[9]) begin
                m_eff[pad] = m_eff[pad] | oh;
                m_pend[pad] = m_pend[pad] & ~oh;
                m_deadline[pad] = c + HOLD;
                m_have[pad] = 1'b1;
            end else if ((m_eff[pad] & oh) != '0) begin
                if (m_have[pad] && c < m_deadline[pad]) m_pend[pad] = m_pend[pad] | oh;
                else m_eff[pad] = m_eff[pad] & ~oh;
            end
        end
        if (io_out && io_n == 3'd2) m_latch = cpu_dout[3:0];
        m_ef3 = new_ef3;
        m_ef4 = new_ef4;
        m_tgl = ps2_key[10];
        m_init = 1'b1;
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_key(input logic [7:0] code, input logic ext, input logic pr);
        ps2_key = {~ps2_key[10], pr, ext, code};
    endtask

    task automatic drive_out(input logic [2:0] n, input logic [7:0] d);
        io_out = 1'b1;
        io_n = n;
        cpu_dout = d;
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        idle(2);
        checks++; if (key_latch !== 4'd0) begin errors++; $display("FAIL reset_latch got %h exp 0", key_latch); end
        checks++; if (ef3_n !== 1'b1) begin errors++; $display("FAIL reset_ef3 got %b exp 1", ef3_n); end
        checks++; if (ef4_n !== 1'b1) begin errors++; $display("FAIL reset_ef4 got %b exp 1", ef4_n); end
        checks++; if (kp1_state !== 10'h0) begin errors++; $display("FAIL reset_kp1 got %h exp 0", kp1_state); end
        checks++; if (kp2_state !== 10'h0) begin errors++; $display("FAIL reset_kp2 got %h exp 0", kp2_state); end
    endtask

    task automatic test_basic();
        drive_out(3'd2, 8'h05);
        drive_key(8'h2E, 1'b0, 1'b1);
        tick();
        io_out = 1'b0;
        checks++; if (key_latch !== 4'd5) begin errors++; $display("FAIL basic_latch got %h exp 5", key_latch); end
        checks++; if (kp1_state !== 10'h020) begin errors++; $display("FAIL basic_kp1 got %h exp 020", kp1_state); end
        checks++; if (ef3_n !== 1'b1) begin errors++; $display("FAIL basic_ef3_early got %b exp 1", ef3_n); end
        tick();
        checks++; if (ef3_n !== 1'b0) begin errors++; $display("FAIL basic_ef3 got %b exp 0", ef3_n); end
        checks++; if (ef4_n !== 1'b1) begin errors++; $display("FAIL basic_ef4 got %b exp 1", ef4_n); end
        drive_key(8'h2E, 1'b0, 1'b0);
        tick();
        idle(120);
        checks++; if (kp1_state !== 10'h0) begin errors++; $display("FAIL basic_cleared got %h exp 0", kp1_state); end
    endtask

    task automatic test_hold();
        drive_out(3'd2, 8'h01);
        tick();
        io_out = 1'b0;
        idle(1);
        drive_key(8'h16, 1'b0, 1'b1);
        tick();
        // k counts cycles since the press event.
        for (int k = 1; k <= 104; k++) begin
            checks++;
            if (kp1_state[1] !== (k <= HOLD)) begin
                errors++;
                $display("FAIL hold_state k=%0d got %b exp %b", k, kp1_state[1], (k <= HOLD));
            end
            if (k >= 2) begin
                checks++;
                if (ef3_n !== (k > HOLD + 1)) begin
                    errors++;
                    $display("FAIL hold_ef3 k=%0d got %b exp %b", k, ef3_n, (k > HOLD + 1));
                end
            end
            if (k == 10) drive_key(8'h16, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic test_long();
        drive_key(8'h16, 1'b0, 1'b1);
        tick();
        idle(200);
        checks++; if (kp1_state[1] !== 1'b1) begin errors++; $display("FAIL long_held got %b exp 1", kp1_state[1]); end
        drive_key(8'h16, 1'b0, 1'b0);
        tick();
        checks++; if (kp1_state[1] !== 1'b0) begin errors++; $display("FAIL long_release got %b exp 0", kp1_state[1]); end
        idle(2);
    endtask

    task automatic test_both();
        drive_out(3'd2, 8'h03);
        tick();
        io_out = 1'b0;
        drive_key(8'h7A, 1'b0, 1'b1);
        tick();
        drive_key(8'h26, 1'b0, 1'b1);
        tick();
        tick();
        checks++; if (ef3_n !== 1'b0) begin errors++; $display("FAIL both_ef3 got %b exp 0", ef3_n); end
        checks++; if (ef4_n !== 1'b0) begin errors++; $display("FAIL both_ef4 got %b exp 0", ef4_n); end
        drive_out(3'd2, 8'h0C);
        tick();
        io_out = 1'b0;
        checks++; if (key_latch !== 4'hC) begin errors++; $display("FAIL both_latch got %h exp c", key_latch); end
        tick();
        checks++; if (ef3_n !== 1'b1) begin errors++; $display("FAIL both_ef3_hi got %b exp 1", ef3_n); end
        checks++; if (ef4_n !== 1'b1) begin errors++; $display("FAIL both_ef4_hi got %b exp 1", ef4_n); end
    endtask

    task automatic test_ignored();
        drive_key(8'h16, 1'b1, 1'b1);
        tick();
        drive_key(8'h1C, 1'b0, 1'b1);
        tick();
        tick();
        checks++; if (kp1_state !== 10'h008) begin errors++; $display("FAIL ign_kp1 got %h exp 008", kp1_state); end
        checks++; if (kp2_state !== 10'h008) begin errors++; $display("FAIL ign_kp2 got %h exp 008", kp2_state); end
        drive_out(3'd2, 8'h01);
        drive_key(8'h16, 1'b0, 1'b1);
        tick();
        io_out = 1'b0;
        checks++; if (ef3_n !== 1'b1) begin errors++; $display("FAIL same_ef3_early got %b exp 1", ef3_n); end
        tick();
        checks++; if (ef3_n !== 1'b0) begin errors++; $display("FAIL same_ef3 got %b exp 0", ef3_n); end
        checks++; if (kp1_state !== 10'h00A) begin errors++; $display("FAIL same_kp1 got %h exp 00a", kp1_state); end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] code;
        for (int it = 0; it < 3000; it++) begin
            // Alternate dense bursts with sparse stretches so holds both overlap and expire.
            if (((it / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 149) == 0)) begin
                r = $urandom_range(0, 21);
                if (r < 10) code = kp1_codes[r];
                else if (r < 20) code = kp2_codes[r - 10];
                else code = (r == 20) ? 8'h1C : 8'($urandom);
                drive_key(code, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 9) == 0) begin
                drive_out(($urandom_range(0, 1) == 1) ? 3'd2 : 3'($urandom_range(0, 7)),
                          8'($urandom));
            end
            tick();
            io_out = 1'b0;
            checks++; if (kp1_state !== m_eff[0]) begin errors++; $display("FAIL rnd_kp1 it=%0d got %h exp %h", it, kp1_state, m_eff[0]); end
            checks++; if (kp2_state !== m_eff[1]) begin errors++; $display("FAIL rnd_kp2 it=%0d got %h exp %h", it, kp2_state, m_eff[1]); end
            checks++; if (key_latch !== m_latch) begin errors++; $display("FAIL rnd_latch it=%0d got %h exp %h", it, key_latch, m_latch); end
            checks++; if (ef3_n !== m_ef3) begin errors++; $display("FAIL rnd_ef3 it=%0d got %b exp %b", it, ef3_n, m_ef3); end
            checks++; if (ef4_n !== m_ef4) begin errors++; $display("FAIL rnd_ef4 it=%0d got %b exp %b", it, ef4_n, m_ef4); end
        end
    endtask

    task automatic test_reset_mid();
        idle(150);
        drive_out(3'd2, 8'h00);
        tick();
        io_out = 1'b0;
        drive_key(8'h45, 1'b0, 1'b1);
        tick();
        idle(3);
        checks++; if (ef3_n !== 1'b0) begin errors++; $display("FAIL mid_pre_ef3 got %b exp 0", ef3_n); end
        reset_n = 1'b0;
        #1;
        checks++; if (kp1_state !== 10'h0) begin errors++; $display("FAIL mid_async_kp1 got %h exp 0", kp1_state); end
        checks++; if (ef3_n !== 1'b1) begin errors++; $display("FAIL mid_async_ef3 got %b exp 1", ef3_n); end
        checks++; if (key_latch !== 4'd0) begin errors++; $display("FAIL mid_async_latch got %h exp 0", key_latch); end
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        model_reset();
        idle(5);
        checks++; if (kp1_state !== 10'h0) begin errors++; $display("FAIL mid_post_kp1 got %h exp 0", kp1_state); end
        checks++; if (kp2_state !== 10'h0) begin errors++; $display("FAIL mid_post_kp2 got %h exp 0", kp2_state); end
        checks++; if (ef3_n !== 1'b1) begin errors++; $display("FAIL mid_post_ef3 got %b exp 1", ef3_n); end
        checks++; if (ef4_n !== 1'b1) begin errors++; $display("FAIL mid_post_ef4 got %b exp 1", ef4_n); end
        // A release now must not revive anything, since no hold survives reset.
        drive_key(8'h45, 1'b0, 1'b0);
        tick();
        idle(1);
        checks++; if (kp1_state !== 10'h0) begin errors++; $display("FAIL mid_rel_kp1 got %h exp 0", kp1_state); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_long();
        test_both();
        test_ignored();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
